counter_n: RTL and testbench

Free-running, parameterizable binary up-counter with asynchronous active-low reset. It increments once per rising clock edge and wraps modulo 2^CNT_WIDTH. It serves as a generic timebase and sequencing source for surrounding logic, and also provides a terminal-count flag and a Gray-coded copy of the count for consumers that need them.

---
 rtl/counter_n_if.sv | 24 ++
 rtl/counter_n.sv | 41 ++++
 tb/tb_counter_n.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/counter_n_if.sv
// counter_n_if: output bundle of counter_n.
//   counter      - current binary count
//   tc           - terminal count, high while counter is all-ones
//   counter_gray - Gray-coded copy of counter
// Modports: master (driven by counter_n), slave (consumers).
interface counter_n_if #(
    parameter int unsigned CNT_WIDTH = 3
);
    logic [CNT_WIDTH-1:0] counter;
    logic                 tc;
    logic [CNT_WIDTH-1:0] counter_gray;

    modport master (
        output counter,
        output tc,
        output counter_gray
    );

    modport slave (
        input counter,
        input tc,
        input counter_gray
    );
endinterface

// File: rtl/counter_n.sv
// counter_n: free-running binary up-counter, wraps modulo 2^CNT_WIDTH.
// Also provides a registered terminal-count flag and a registered Gray copy.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset, clears all outputs at once
//   bus     - counter_n_if master modport (counter, tc, counter_gray)
module counter_n #(
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    counter_n_if.master        bus
);
    logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;
    logic [CNT_WIDTH-1:0] gray_q, gray_d;
    logic                 tc_q,   tc_d;

    // tc and Gray are derived from the next count so all three outputs
    // update together on the same edge and stay mutually consistent.
    always_comb begin
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        gray_d = cnt_d ^ (cnt_d >> 1);
        tc_d   = &cnt_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.counter      = cnt_q;
    assign bus.counter_gray = gray_q;
    assign bus.tc           = tc_q;
endmodule

// File: tb/tb_counter_n.sv
// tb_counter_n: scoreboard bench for counter_n at widths 3, 1 and 8,
// sharing one clock and one reset.
module tb_counter_n;
    logic clk;
    logic reset_n;

    counter_n_if #(.CNT_WIDTH(3)) if3 ();
    counter_n_if #(.CNT_WIDTH(1)) if1 ();
    counter_n_if #(.CNT_WIDTH(8)) if8 ();

    counter_n #(.CNT_WIDTH(3)) u_cnt3 (.clk(clk), .reset_n(reset_n), .bus(if3));
    counter_n #(.CNT_WIDTH(1)) u_cnt1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    counter_n #(.CNT_WIDTH(8)) u_cnt8 (.clk(clk), .reset_n(reset_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned c3, g3, t3;
        int unsigned c1, g1, t1;
        int unsigned c8, g8, t8;
    } exp_t;

    exp_t sb_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;

    // reference model state
    int unsigned m3 = 0, m1 = 0, m8 = 0;
    int unsigned gray3_tbl [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    logic [31:0] prev_g3, prev_g8;
    int unsigned tc8_hits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.c3 = m3;  e.g3 = gray3_tbl[m3];  e.t3 = (m3 == 7)   ? 1 : 0;
        e.c1 = m1;  e.g1 = m1;             e.t1 = m1;
        e.c8 = m8;  e.g8 = m8 ^ (m8 / 2);  e.t8 = (m8 == 255) ? 1 : 0;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_cnt3"},  32'(if3.counter),      e.c3);
            chk({tag, "_gray3"}, 32'(if3.counter_gray), e.g3);
            chk({tag, "_tc3"},   32'(if3.tc),           e.t3);
            chk({tag, "_cnt1"},  32'(if1.counter),      e.c1);
            chk({tag, "_gray1"}, 32'(if1.counter_gray), e.g1);
            chk({tag, "_tc1"},   32'(if1.tc),           e.t1);
            chk({tag, "_cnt8"},  32'(if8.counter),      e.c8);
            chk({tag, "_gray8"}, 32'(if8.counter_gray), e.g8);
            chk({tag, "_tc8"},   32'(if8.tc),           e.t8);
        end
    endtask

    task automatic model_reset();
        m3 = 0; m1 = 0; m8 = 0;
    endtask

    // One counting edge: predict, wait for edge, compare #1 after it.
    task automatic step(input string tag);
        m3 = (m3 + 1) % 8;
        m1 = (m1 + 1) % 2;
        m8 = (m8 + 1) % 256;
        sb_q.push_back(snap());
        prev_g3 = 32'(if3.counter_gray);
        prev_g8 = 32'(if8.counter_gray);
        @(posedge clk);
        #1;
        pop_check(tag);
        chk({tag, "_g3_onebit"}, 32'($countones(prev_g3 ^ 32'(if3.counter_gray))), 32'd1);
        chk({tag, "_g8_onebit"}, 32'($countones(prev_g8 ^ 32'(if8.counter_gray))), 32'd1);
        if (if8.tc) tc8_hits++;
    endtask

    initial begin
        reset_n = 1'b1;
        #2;
        // asynchronous assertion between edges
        reset_n = 1'b0;
        model_reset();
        sb_q.push_back(snap());
        #1;
        pop_check("por");

        // reset held across 5 edges
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(snap());
            @(posedge clk);
            #1;
            pop_check("hold");
        end

        // release away from the edge
        #2;
        reset_n = 1'b1;

        // count/wrap and one full Gray period
        for (int i = 0; i < 10; i++) step("run");

        // advance to count 5, then a short reset pulse mid-cycle
        while (m3 != 5) step("pre5");
        chk("at5", 32'(if3.counter), 32'd5);
        #2;
        reset_n = 1'b0;
        model_reset();
        sb_q.push_back(snap());
        #1;
        pop_check("midrst");
        #1;
        reset_n = 1'b1;
        sb_q.push_back(snap());
        #1;
        pop_check("postrel");
        step("first_after");
        chk("first_after_is1", 32'(if3.counter), 32'd1);

        // 8-bit wrap: tc8 high exactly once in 256 consecutive edges
        tc8_hits = 0;
        for (int i = 0; i < 256; i++) step("w8");
        chk("tc8_hits", 32'(tc8_hits), 32'd1);
        step("w8_tail");
        chk("w8_after_wrap", 32'(if8.counter), 32'd2);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard time limit so the run can never hang
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
